// File: rtl/vending_multi_if.sv
// Coin acceptor / selection / dispenser signal bundle for vending_multi.
// The master drives the requests; the slave (controller) drives the pulses back.
interface vending_multi_if #(
  parameter int CREDIT_W = 8
);
  logic                coin_10;
  logic                coin_50;
  logic                coin_100;
  logic                sel_valid;
  logic [1:0]          sel;
  logic                cancel;
  logic                item;
  logic [1:0]          item_id;
  logic [CREDIT_W-1:0] change;
  logic                change_valid;
  logic                coin_reject;
  logic                sel_nack;
  logic [CREDIT_W-1:0] credit;
  logic                busy;

  modport master (
    output coin_10, coin_50, coin_100, sel_valid, sel, cancel,
    input  item, item_id, change, change_valid, coin_reject, sel_nack, credit, busy
  );

  modport slave (
    input  coin_10, coin_50, coin_100, sel_valid, sel, cancel,
    output item, item_id, change, change_valid, coin_reject, sel_nack, credit, busy
  );
endinterface

// File: rtl/vending_multi.sv
// Multi-item vending controller: capped coin credit, four priced items,
// change on vend and full refund on cancel. All outputs are registered.
module vending_multi #(
  parameter int CREDIT_W   = 8,
  parameter int MAX_CREDIT = 200,
  parameter int PRICE0     = 120,
  parameter int PRICE1     = 150,
  parameter int PRICE2     = 60,
  parameter int PRICE3     = 100
) (
  input  logic             clk,
  input  logic             rst,
  vending_multi_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, HOLD, VEND} state_t;

  localparam logic [CREDIT_W:0] MAX_SUM = (CREDIT_W+1)'(MAX_CREDIT);

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] s);
    case (s)
      2'd0:    return CREDIT_W'(PRICE0);
      2'd1:    return CREDIT_W'(PRICE1);
      2'd2:    return CREDIT_W'(PRICE2);
      default: return CREDIT_W'(PRICE3);
    endcase
  endfunction

  state_t              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [1:0]          sel_q;
  logic                item_q;
  logic [1:0]          item_id_q;
  logic [CREDIT_W-1:0] change_q;
  logic                change_valid_q;
  logic                coin_reject_q;
  logic                sel_nack_q;
  logic                busy_q;

  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum_d;
  logic [1:0]          coin_cnt;
  logic                coin_any;
  logic                coin_illegal;

  // NOTE: every variable gets a default before the ifs, otherwise a latch is inferred.
  always_comb begin
    coin_val = '0;
    if (bus.coin_10)  coin_val = (CREDIT_W+1)'(10);
    if (bus.coin_50)  coin_val = (CREDIT_W+1)'(50);
    if (bus.coin_100) coin_val = (CREDIT_W+1)'(100);
    coin_cnt     = 2'(bus.coin_10) + 2'(bus.coin_50) + 2'(bus.coin_100);
    coin_any     = (coin_cnt != 2'd0);
    coin_illegal = coin_any && (coin_cnt > 2'd1 || bus.sel_valid || bus.cancel);
    // One bit wider than credit so the cap compare cannot wrap.
    sum_d        = {1'b0, credit_q} + coin_val;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      sel_q          <= '0;
      item_q         <= 1'b0;
      item_id_q      <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      sel_nack_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      item_q         <= 1'b0;
      item_id_q      <= '0;
      change_q       <= '0;
      change_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      sel_nack_q     <= 1'b0;
      busy_q         <= 1'b0;

      if (state_q == VEND) begin
        // Requests are ignored here; any coin is handed straight back.
        item_q         <= 1'b1;
        item_id_q      <= sel_q;
        change_q       <= credit_q - price_of(sel_q);
        change_valid_q <= 1'b1;
        coin_reject_q  <= coin_any;
        credit_q       <= '0;
        state_q        <= IDLE;
      end else begin
        if (coin_illegal) coin_reject_q <= 1'b1;

        if (bus.cancel) begin
          if (credit_q != '0) begin
            change_q       <= credit_q;
            change_valid_q <= 1'b1;
          end
          credit_q <= '0;
          state_q  <= IDLE;
        end else if (bus.sel_valid) begin
          if (credit_q >= price_of(bus.sel)) begin
            sel_q   <= bus.sel;
            busy_q  <= 1'b1;
            state_q <= VEND;
          end else begin
            sel_nack_q <= 1'b1;
          end
        end else if (coin_any && !coin_illegal) begin
          if (sum_d <= MAX_SUM) begin
            credit_q <= sum_d[CREDIT_W-1:0];
            state_q  <= (sum_d != '0) ? HOLD : IDLE;
          end else begin
            coin_reject_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.item         = item_q;
  assign bus.item_id      = item_id_q;
  assign bus.change       = change_q;
  assign bus.change_valid = change_valid_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.sel_nack     = sel_nack_q;
  assign bus.credit       = credit_q;
  assign bus.busy         = busy_q;

endmodule
